// File: rtl/store_queue_mp_pkg.sv
// Shared store-queue definitions (package sys_defs).
// Holds the queue entry layout, the default queue depth, the forwarding
// lookup result layout and a byte-enable to bit-mask helper.
package sys_defs;

  localparam int LSQ_SZ = 8;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int BE_W   = 4;

  typedef struct packed {
    logic [ADDR_W-1:0] address;
    logic [DATA_W-1:0] data;
    logic [BE_W-1:0]   byte_enable;
  } store_queue_entry_t;

  typedef struct packed {
    logic              hit;
    logic              partial;
    logic [DATA_W-1:0] data;
  } sq_lookup_result_t;

  // Expand a per-byte enable into a per-bit data mask.
  function automatic logic [DATA_W-1:0] be_to_mask(input logic [BE_W-1:0] be);
    logic [DATA_W-1:0] m;
    m = '0;
    for (int b = 0; b < BE_W; b++) begin
      m[b*8 +: 8] = {8{be[b]}};
    end
    return m;
  endfunction

endpackage

// File: rtl/store_queue_mp_search.sv
// sq_forward_search: combinational youngest-match search for store-to-load
// forwarding.
// Ports:
//   entries_i            entry storage array (indexed by physical slot)
//   head_i               physical slot of the oldest valid entry
//   count_i              number of valid entries
//   lookup_address_i     word-aligned load address
//   lookup_byte_enable_i bytes the load needs
//   result_o             hit / partial / forwarded data (unregistered)
module sq_forward_search
  import sys_defs::*;
#(
  parameter int DEPTH = LSQ_SZ,
  parameter int IDX_W = $clog2(DEPTH),
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  store_queue_entry_t entries_i [DEPTH],
  input  logic [IDX_W-1:0]   head_i,
  input  logic [CNT_W-1:0]   count_i,
  input  logic [ADDR_W-1:0]  lookup_address_i,
  input  logic [BE_W-1:0]    lookup_byte_enable_i,
  output sq_lookup_result_t  result_o
);

  store_queue_entry_t sel;
  logic               found;
  logic [BE_W-1:0]    covered;

  // Walk from oldest to youngest; a later match overwrites an earlier one,
  // so the surviving selection is the youngest matching store.
  always_comb begin
    int               p;
    logic [IDX_W-1:0] pi;
    found = 1'b0;
    sel   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      p = int'(head_i) + i;
      if (p >= DEPTH) p = p - DEPTH;
      pi = IDX_W'(p);
      if ((CNT_W'(i) < count_i) &&
          (entries_i[pi].address == lookup_address_i) &&
          (|(entries_i[pi].byte_enable & lookup_byte_enable_i))) begin
        found = 1'b1;
        sel   = entries_i[pi];
      end
    end
  end

  always_comb begin
    covered          = sel.byte_enable & lookup_byte_enable_i;
    result_o.hit     = found && (covered == lookup_byte_enable_i);
    result_o.partial = found && (covered != lookup_byte_enable_i);
    // Only bytes both requested and written by the selected store are forwarded.
    result_o.data    = found ? (sel.data & be_to_mask(covered)) : '0;
  end

endmodule

// File: rtl/store_queue_mp.sv
// store_queue_mp: multi-lane in-order store queue with single retire port,
// registered store-to-load forwarding lookup and whole-queue flush.
// Ports:
//   clock, reset                       clock / asynchronous active-high reset
//   flush_i                            discard all entries this cycle
//   enqueue_request_i [ENQ_LANES]      per-lane request, contiguous from lane 0
//   enqueue_store_*_i                  per-lane address / data / byte enables
//   enqueue_accepted_o [ENQ_LANES]     registered per-lane accept pulse
//   free_slots_o                       registered free-entry count
//   dequeue_request_i                  retire request
//   dequeue_store_*_o                  retired entry (held until next retire)
//   dequeue_accepted_o                 registered retire pulse
//   lookup_valid_i/address_i/byte_enable_i  load forwarding query
//   lookup_done_o/hit_o/partial_o/data_o    registered query result
module store_queue_mp
  import sys_defs::*;
#(
  parameter int DEPTH     = LSQ_SZ,
  parameter int ENQ_LANES = 2
) (
  input  logic                               clock,
  input  logic                               reset,
  input  logic                               flush_i,
  input  logic [ENQ_LANES-1:0]               enqueue_request_i,
  input  logic [ENQ_LANES-1:0][ADDR_W-1:0]   enqueue_store_address_i,
  input  logic [ENQ_LANES-1:0][DATA_W-1:0]   enqueue_store_data_i,
  input  logic [ENQ_LANES-1:0][BE_W-1:0]     enqueue_store_byte_enable_i,
  output logic [ENQ_LANES-1:0]               enqueue_accepted_o,
  output logic [$clog2(DEPTH+1)-1:0]         free_slots_o,
  input  logic                               dequeue_request_i,
  output logic [ADDR_W-1:0]                  dequeue_store_address_o,
  output logic [DATA_W-1:0]                  dequeue_store_data_o,
  output logic [BE_W-1:0]                    dequeue_store_byte_enable_o,
  output logic                               dequeue_accepted_o,
  input  logic                               lookup_valid_i,
  input  logic [ADDR_W-1:0]                  lookup_address_i,
  input  logic [BE_W-1:0]                    lookup_byte_enable_i,
  output logic                               lookup_done_o,
  output logic                               lookup_hit_o,
  output logic                               lookup_partial_o,
  output logic [DATA_W-1:0]                  lookup_data_o
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  store_queue_entry_t entry_q [DEPTH];

  logic [IDX_W-1:0]     head_q, head_d;
  logic [IDX_W-1:0]     tail_q, tail_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic [CNT_W-1:0]     free_q, free_d;
  logic [ENQ_LANES-1:0] acc_q, acc_d;
  logic                 deq_acc_q, deq_acc_d;
  store_queue_entry_t   deq_entry_q, deq_entry_d;
  logic                 lk_done_q;
  sq_lookup_result_t    lk_res_q, lk_res_c;

  logic [ENQ_LANES-1:0] wr_en;
  logic [IDX_W-1:0]     wr_idx [ENQ_LANES];
  logic                 will_deq;

  // Modular add with an explicit wrap compare; off never exceeds DEPTH.
  function automatic logic [IDX_W-1:0] wrap_add(input logic [IDX_W-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= DEPTH) s = s - DEPTH;
    return IDX_W'(s);
  endfunction

  always_comb begin
    int nreq;
    int avail;
    int k;
    int cnt_next;
    head_d      = head_q;
    tail_d      = tail_q;
    count_d     = count_q;
    free_d      = free_q;
    acc_d       = '0;
    deq_acc_d   = 1'b0;
    deq_entry_d = deq_entry_q;
    wr_en       = '0;
    for (int l = 0; l < ENQ_LANES; l++) wr_idx[l] = '0;

    will_deq = dequeue_request_i && (count_q != '0);

    // Length of the contiguous request prefix starting at lane 0.
    nreq = 0;
    for (int l = 0; l < ENQ_LANES; l++) begin
      if (enqueue_request_i[l] && (nreq == l)) nreq = nreq + 1;
    end

    // A same-cycle retire frees a slot the enqueue may reuse.
    avail    = DEPTH - int'(count_q) + (will_deq ? 1 : 0);
    k        = (nreq < avail) ? nreq : avail;
    cnt_next = int'(count_q) + k - (will_deq ? 1 : 0);

    if (flush_i) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
      free_d  = CNT_W'(DEPTH);
    end else begin
      for (int l = 0; l < ENQ_LANES; l++) begin
        if (l < k) begin
          acc_d[l]  = 1'b1;
          wr_en[l]  = 1'b1;
          wr_idx[l] = wrap_add(tail_q, l);
        end
      end
      tail_d = wrap_add(tail_q, k);
      if (will_deq) begin
        head_d      = wrap_add(head_q, 1);
        deq_entry_d = entry_q[head_q];
        deq_acc_d   = 1'b1;
      end
      count_d = CNT_W'(cnt_next);
      free_d  = CNT_W'(DEPTH - cnt_next);
    end
  end

  sq_forward_search #(
    .DEPTH (DEPTH),
    .IDX_W (IDX_W),
    .CNT_W (CNT_W)
  ) u_search (
    .entries_i            (entry_q),
    .head_i               (head_q),
    .count_i              (count_q),
    .lookup_address_i     (lookup_address_i),
    .lookup_byte_enable_i (lookup_byte_enable_i),
    .result_o             (lk_res_c)
  );

  // Entry storage is deliberately not reset; validity comes from head/count.
  always_ff @(posedge clock) begin
    for (int l = 0; l < ENQ_LANES; l++) begin
      if (wr_en[l]) begin
        entry_q[wr_idx[l]] <= '{address:     enqueue_store_address_i[l],
                                data:        enqueue_store_data_i[l],
                                byte_enable: enqueue_store_byte_enable_i[l]};
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      free_q      <= '0;
      acc_q       <= '0;
      deq_acc_q   <= 1'b0;
      deq_entry_q <= '0;
      lk_done_q   <= 1'b0;
      lk_res_q    <= '0;
    end else begin
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      free_q      <= free_d;
      acc_q       <= acc_d;
      deq_acc_q   <= deq_acc_d;
      deq_entry_q <= deq_entry_d;
      // Lookup sees pre-update contents, so it completes even under flush.
      lk_done_q   <= lookup_valid_i;
      lk_res_q    <= lookup_valid_i ? lk_res_c : '0;
    end
  end

  assign enqueue_accepted_o          = acc_q;
  assign free_slots_o                = free_q;
  assign dequeue_accepted_o          = deq_acc_q;
  assign dequeue_store_address_o     = deq_entry_q.address;
  assign dequeue_store_data_o        = deq_entry_q.data;
  assign dequeue_store_byte_enable_o = deq_entry_q.byte_enable;
  assign lookup_done_o               = lk_done_q;
  assign lookup_hit_o                = lk_res_q.hit;
  assign lookup_partial_o            = lk_res_q.partial;
  assign lookup_data_o               = lk_res_q.data;

endmodule

// File: tb/tb_store_queue_mp.sv
module tb_store_queue_mp;

  localparam int DEPTH = 8;
  localparam int LANES = 2;

  logic                  clock = 1'b0;
  logic                  reset = 1'b1;
  logic                  flush = 1'b0;
  logic [LANES-1:0]      enq_req = '0;
  logic [LANES-1:0][31:0] enq_addr = '0;
  logic [LANES-1:0][31:0] enq_data = '0;
  logic [LANES-1:0][3:0] enq_be = '0;
  logic [LANES-1:0]      enq_acc;
  logic [3:0]            free;
  logic                  deq_req = 1'b0;
  logic [31:0]           deq_addr, deq_data;
  logic [3:0]            deq_be;
  logic                  deq_acc;
  logic                  lk_v = 1'b0;
  logic [31:0]           lk_a = '0;
  logic [3:0]            lk_be = '0;
  logic                  lk_done, lk_hit, lk_part;
  logic [31:0]           lk_data;

  store_queue_mp #(.DEPTH(DEPTH), .ENQ_LANES(LANES)) dut (
    .clock                       (clock),
    .reset                       (reset),
    .flush_i                     (flush),
    .enqueue_request_i           (enq_req),
    .enqueue_store_address_i     (enq_addr),
    .enqueue_store_data_i        (enq_data),
    .enqueue_store_byte_enable_i (enq_be),
    .enqueue_accepted_o          (enq_acc),
    .free_slots_o                (free),
    .dequeue_request_i           (deq_req),
    .dequeue_store_address_o     (deq_addr),
    .dequeue_store_data_o        (deq_data),
    .dequeue_store_byte_enable_o (deq_be),
    .dequeue_accepted_o          (deq_acc),
    .lookup_valid_i              (lk_v),
    .lookup_address_i            (lk_a),
    .lookup_byte_enable_i        (lk_be),
    .lookup_done_o               (lk_done),
    .lookup_hit_o                (lk_hit),
    .lookup_partial_o            (lk_part),
    .lookup_data_o               (lk_data)
  );

  always #5 clock = ~clock;

  // Requests must be contiguous from lane 0.
  always @(posedge clock) begin
    if (!reset) begin
      assert (!(enq_req[1] && !enq_req[0])) else $error("illegal non-contiguous enqueue request");
    end
  end

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  b;
  } ent_t;

  ent_t sb[$];   // scoreboard: stores expected to retire, oldest first

  int n_tests = 0;
  int n_fail  = 0;

  logic [1:0]  exp_acc;
  logic [3:0]  exp_free;
  logic        exp_deq_acc;
  logic [31:0] exp_deq_a = '0, exp_deq_d = '0;
  logic [3:0]  exp_deq_b = '0;
  logic        exp_done, exp_hit, exp_part;
  logic [31:0] exp_ldata;

  task automatic set_lane(input int l, input logic [31:0] a, input logic [31:0] d, input logic [3:0] b);
    enq_addr[l] = a;
    enq_data[l] = d;
    enq_be[l]   = b;
  endtask

  // Predict this cycle's outputs from the current inputs, advance one clock,
  // then return the inputs to idle.
  task automatic step();
    int   nreq, avail, k;
    logic wd, found;
    ent_t e;
    logic [3:0] cov;
    exp_done = lk_v; exp_hit = 1'b0; exp_part = 1'b0; exp_ldata = '0; found = 1'b0;
    if (lk_v) begin
      for (int i = sb.size() - 1; i >= 0; i--) begin
        if (!found && sb[i].a == lk_a && (sb[i].b & lk_be) != 4'h0) begin
          found = 1'b1;
          cov   = sb[i].b & lk_be;
          exp_hit  = (cov == lk_be);
          exp_part = (cov != lk_be);
          for (int j = 0; j < 4; j++) if (cov[j]) exp_ldata[j*8 +: 8] = sb[i].d[j*8 +: 8];
        end
      end
    end
    if (flush) begin
      exp_acc = 2'b00; exp_deq_acc = 1'b0; sb.delete(); exp_free = 4'd8;
    end else begin
      wd    = deq_req && (sb.size() != 0);
      nreq  = enq_req[0] ? (enq_req[1] ? 2 : 1) : 0;
      avail = DEPTH - sb.size() + (wd ? 1 : 0);
      k     = (nreq < avail) ? nreq : avail;
      exp_acc = (k == 2) ? 2'b11 : ((k == 1) ? 2'b01 : 2'b00);
      exp_deq_acc = wd;
      if (wd) begin
        e = sb.pop_front();
        exp_deq_a = e.a; exp_deq_d = e.d; exp_deq_b = e.b;
      end
      for (int l = 0; l < k; l++) sb.push_back('{a: enq_addr[l], d: enq_data[l], b: enq_be[l]});
      exp_free = 4'(DEPTH - sb.size());
    end
    @(posedge clock);
    #1;
    enq_req = '0; deq_req = 1'b0; flush = 1'b0; lk_v = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    n_tests++; if (enq_acc !== 2'b00) begin n_fail++; $display("FAIL reset_acc got %h want 0", enq_acc); end
    n_tests++; if (free !== 4'd0) begin n_fail++; $display("FAIL reset_free got %0d want 0", free); end
    n_tests++; if (deq_acc !== 1'b0 || deq_addr !== 32'h0 || deq_data !== 32'h0 || deq_be !== 4'h0) begin
      n_fail++; $display("FAIL reset_deq got acc=%b a=%h d=%h be=%h want all 0", deq_acc, deq_addr, deq_data, deq_be); end
    n_tests++; if (lk_done !== 1'b0 || lk_hit !== 1'b0 || lk_part !== 1'b0 || lk_data !== 32'h0) begin
      n_fail++; $display("FAIL reset_lookup got done=%b hit=%b part=%b d=%h want all 0", lk_done, lk_hit, lk_part, lk_data); end
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock); #1;
  endtask

  task automatic test_fill_wrap();
    for (int c = 0; c < 4; c++) begin
      set_lane(0, 32'h1000 + 32'(c * 8), 32'hD000_0000 + 32'(2 * c), 4'hF);
      set_lane(1, 32'h1004 + 32'(c * 8), 32'hD000_0001 + 32'(2 * c), 4'hF);
      enq_req = 2'b11;
      step();
      n_tests++; if (enq_acc !== 2'b11) begin n_fail++; $display("FAIL fill_acc%0d got %b want 11", c, enq_acc); end
      n_tests++; if (free !== 4'(6 - 2 * c)) begin n_fail++; $display("FAIL fill_free%0d got %0d want %0d", c, free, 6 - 2 * c); end
    end
    set_lane(0, 32'h2000, 32'hBAD0_0000, 4'hF);
    set_lane(1, 32'h2004, 32'hBAD0_0001, 4'hF);
    enq_req = 2'b11;
    step();
    n_tests++; if (enq_acc !== 2'b00) begin n_fail++; $display("FAIL full_reject got %b want 00", enq_acc); end
    n_tests++; if (free !== 4'd0) begin n_fail++; $display("FAIL full_free got %0d want 0", free); end
  endtask

  task automatic test_full_dequeue();
    for (int c = 0; c < 6; c++) begin
      set_lane(0, 32'h3000 + 32'(c * 8), 32'hE000_0000 + 32'(c), 4'(c + 1));
      set_lane(1, 32'h3004 + 32'(c * 8), 32'hEEEE_0000 + 32'(c), 4'hF);
      enq_req = 2'b11; deq_req = 1'b1;
      step();
      n_tests++; if (enq_acc !== 2'b01) begin n_fail++; $display("FAIL fulldeq_acc%0d got %b want 01", c, enq_acc); end
      n_tests++; if (deq_acc !== 1'b1) begin n_fail++; $display("FAIL fulldeq_pulse%0d got %b want 1", c, deq_acc); end
      n_tests++; if (deq_addr !== exp_deq_a || deq_data !== exp_deq_d || deq_be !== exp_deq_b) begin
        n_fail++; $display("FAIL fulldeq_data%0d got %h/%h/%h want %h/%h/%h", c, deq_addr, deq_data, deq_be, exp_deq_a, exp_deq_d, exp_deq_b); end
      n_tests++; if (free !== 4'd0) begin n_fail++; $display("FAIL fulldeq_free%0d got %0d want 0", c, free); end
    end
    for (int c = 0; c < 8; c++) begin
      deq_req = 1'b1;
      step();
      n_tests++; if (deq_acc !== 1'b1 || deq_addr !== exp_deq_a || deq_data !== exp_deq_d || deq_be !== exp_deq_b) begin
        n_fail++; $display("FAIL drain%0d got %b %h/%h/%h want 1 %h/%h/%h", c, deq_acc, deq_addr, deq_data, deq_be, exp_deq_a, exp_deq_d, exp_deq_b); end
    end
    n_tests++; if (free !== 4'd8) begin n_fail++; $display("FAIL drain_free got %0d want 8", free); end
  endtask

  task automatic test_forward();
    set_lane(0, 32'h100, 32'hAABBCCDD, 4'hF);
    set_lane(1, 32'h100, 32'h11223344, 4'h3);
    enq_req = 2'b11;
    step();
    n_tests++; if (enq_acc !== 2'b11) begin n_fail++; $display("FAIL fwd_enq got %b want 11", enq_acc); end
    lk_v = 1'b1; lk_a = 32'h100; lk_be = 4'h3;
    step();
    n_tests++; if (lk_done !== 1'b1 || lk_hit !== 1'b1 || lk_part !== 1'b0 || lk_data !== 32'h0000_3344) begin
      n_fail++; $display("FAIL fwd_hit got done=%b hit=%b part=%b d=%h want 1 1 0 00003344", lk_done, lk_hit, lk_part, lk_data); end
    // Youngest intersecting store (be 3) covers byte 1 but not byte 2.
    lk_v = 1'b1; lk_a = 32'h100; lk_be = 4'h6;
    step();
    n_tests++; if (lk_done !== 1'b1 || lk_hit !== 1'b0 || lk_part !== 1'b1) begin
      n_fail++; $display("FAIL fwd_partial got done=%b hit=%b part=%b want 1 0 1", lk_done, lk_hit, lk_part); end
    // Upper bytes only intersect the older full-word store.
    lk_v = 1'b1; lk_a = 32'h100; lk_be = 4'hC;
    step();
    n_tests++; if (lk_hit !== 1'b1 || lk_part !== 1'b0 || lk_data !== 32'hAABB_0000 || lk_data !== exp_ldata) begin
      n_fail++; $display("FAIL fwd_older got hit=%b part=%b d=%h want 1 0 aabb0000", lk_hit, lk_part, lk_data); end
    for (int c = 0; c < 2; c++) begin
      deq_req = 1'b1;
      step();
      n_tests++; if (deq_acc !== 1'b1 || deq_data !== exp_deq_d) begin
        n_fail++; $display("FAIL fwd_drain%0d got %b %h want 1 %h", c, deq_acc, deq_data, exp_deq_d); end
    end
  endtask

  task automatic test_miss_same_cycle();
    set_lane(0, 32'h200, 32'hCAFEF00D, 4'hF);
    enq_req = 2'b01;
    lk_v = 1'b1; lk_a = 32'h200; lk_be = 4'hF;
    step();
    n_tests++; if (lk_done !== 1'b1 || lk_hit !== 1'b0 || lk_part !== 1'b0 || enq_acc !== 2'b01) begin
      n_fail++; $display("FAIL same_cycle got done=%b hit=%b part=%b acc=%b want 1 0 0 01", lk_done, lk_hit, lk_part, enq_acc); end
    lk_v = 1'b1; lk_a = 32'h200; lk_be = 4'hF;
    step();
    n_tests++; if (lk_hit !== 1'b1 || lk_data !== 32'hCAFEF00D) begin
      n_fail++; $display("FAIL next_cycle_hit got hit=%b d=%h want 1 cafef00d", lk_hit, lk_data); end
    lk_v = 1'b1; lk_a = 32'h204; lk_be = 4'hF;
    step();
    n_tests++; if (lk_done !== 1'b1 || lk_hit !== 1'b0 || lk_part !== exp_part || lk_data !== 32'h0) begin
      n_fail++; $display("FAIL addr_miss got done=%b hit=%b part=%b d=%h want 1 0 0 0", lk_done, lk_hit, lk_part, lk_data); end
    deq_req = 1'b1;
    step();
    n_tests++; if (deq_acc !== 1'b1 || deq_addr !== 32'h200) begin
      n_fail++; $display("FAIL miss_drain got %b %h want 1 00000200", deq_acc, deq_addr); end
  endtask

  task automatic test_flush();
    for (int c = 0; c < 3; c++) begin
      set_lane(0, 32'h400 + 32'(c * 8), 32'h4400_0000 + 32'(c), 4'hF);
      set_lane(1, 32'h404 + 32'(c * 8), 32'h4411_0000 + 32'(c), 4'hF);
      enq_req = (c == 2) ? 2'b01 : 2'b11;
      step();
    end
    n_tests++; if (free !== 4'd3) begin n_fail++; $display("FAIL preflush_free got %0d want 3", free); end
    flush = 1'b1; enq_req = 2'b11; deq_req = 1'b1;
    set_lane(0, 32'h500, 32'h0, 4'hF); set_lane(1, 32'h504, 32'h0, 4'hF);
    lk_v = 1'b1; lk_a = 32'h408; lk_be = 4'hF;
    step();
    n_tests++; if (enq_acc !== 2'b00 || deq_acc !== 1'b0) begin
      n_fail++; $display("FAIL flush_pulses got acc=%b deq=%b want 00 0", enq_acc, deq_acc); end
    n_tests++; if (free !== 4'd8) begin n_fail++; $display("FAIL flush_free got %0d want 8", free); end
    n_tests++; if (lk_hit !== 1'b1 || lk_data !== 32'h4400_0001) begin
      n_fail++; $display("FAIL flush_lookup got hit=%b d=%h want 1 44000001", lk_hit, lk_data); end
    set_lane(0, 32'h300, 32'h3333_3333, 4'hF);
    enq_req = 2'b01;
    step();
    n_tests++; if (enq_acc !== 2'b01 || free !== 4'd7) begin
      n_fail++; $display("FAIL postflush_enq got acc=%b free=%0d want 01 7", enq_acc, free); end
    deq_req = 1'b1;
    step();
    n_tests++; if (deq_acc !== 1'b1 || deq_addr !== 32'h300 || deq_data !== 32'h3333_3333 || free !== 4'd8) begin
      n_fail++; $display("FAIL postflush_deq got %b %h %h free=%0d want 1 300 33333333 8", deq_acc, deq_addr, deq_data, free); end
  endtask

  task automatic test_async_reset();
    set_lane(0, 32'h600, 32'h6666_0000, 4'hF);
    set_lane(1, 32'h604, 32'h6666_0001, 4'hF);
    enq_req = 2'b11;
    lk_v = 1'b1; lk_a = 32'h300; lk_be = 4'hF;
    step();
    n_tests++; if (enq_acc !== 2'b11 || free !== 4'd6) begin
      n_fail++; $display("FAIL burst_pre got acc=%b free=%0d want 11 6", enq_acc, free); end
    #3 reset = 1'b1;
    #1;
    n_tests++; if (enq_acc !== 2'b00 || free !== 4'd0 || deq_acc !== 1'b0 || deq_addr !== 32'h0 || deq_data !== 32'h0) begin
      n_fail++; $display("FAIL async_reset got acc=%b free=%0d deq=%b a=%h d=%h want all 0", enq_acc, free, deq_acc, deq_addr, deq_data); end
    n_tests++; if (lk_done !== 1'b0 || lk_hit !== 1'b0 || lk_data !== 32'h0) begin
      n_fail++; $display("FAIL async_reset_lk got done=%b hit=%b d=%h want 0", lk_done, lk_hit, lk_data); end
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    sb.delete();
    exp_deq_a = '0; exp_deq_d = '0; exp_deq_b = '0;
    lk_v = 1'b1; lk_a = 32'h600; lk_be = 4'hF; deq_req = 1'b1;
    step();
    n_tests++; if (lk_done !== 1'b1 || lk_hit !== 1'b0 || lk_part !== 1'b0) begin
      n_fail++; $display("FAIL post_reset_lookup got done=%b hit=%b part=%b want 1 0 0", lk_done, lk_hit, lk_part); end
    n_tests++; if (deq_acc !== 1'b0 || free !== 4'd8) begin
      n_fail++; $display("FAIL post_reset_empty got deq=%b free=%0d want 0 8", deq_acc, free); end
  endtask

  initial begin
    test_reset();
    test_fill_wrap();
    test_full_dequeue();
    test_forward();
    test_miss_same_cycle();
    test_flush();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
